// File: rtl/snn_pkg.sv
// Shared defaults and types for the spike memory writer and reader pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snn_pkg;

    localparam int SIZE_SPIKE_DEF          = 10;
    localparam int SIZE_SPIKE_MAX_DEF      = 512;
    localparam int NUM_TIMESTEPS_DEF       = 10;
    localparam int SIZE_ADDR_SPIKE_MEM_DEF = 13;
    localparam int SIZE_ADDR_STEP_DEF      = 4;
    localparam int SIZE_COUNT_DEF          = 10;

    // Total index-list words for one layer pass.
    localparam int SPIKE_MEM_DEPTH = SIZE_SPIKE_MAX_DEF * NUM_TIMESTEPS_DEF;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE_COUNT,
        DONE
    } state_t;

endpackage

// File: rtl/spike_slot_counter.sv
// Per-timestep slot counter with saturation, sticky overflow and running step base address.
// Latency: slot/base/overflow update on the edge after the controlling strobe; wr_addr is combinational.
// Backpressure: none; accepts beyond saturation are counted as drops via overflow.
module spike_slot_counter
    import snn_pkg::*;
#(
    parameter int size_spike_max      = SIZE_SPIKE_MAX_DEF,
    parameter int size_addr_spike_mem = SIZE_ADDR_SPIKE_MEM_DEF,
    parameter int size_count          = SIZE_COUNT_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           accept,
    input  logic                           step_close,
    input  logic                           step_adv,
    output logic [size_count-1:0]          slot,
    output logic [size_addr_spike_mem-1:0] wr_addr,
    output logic                           saturated,
    output logic                           overflow
);

    logic [size_addr_spike_mem-1:0] base_q;

    assign saturated = (slot == size_count'(size_spike_max));
    // Base replaces step*size_spike_max so no multiplier is needed.
    assign wr_addr   = base_q + size_addr_spike_mem'(slot);

    // Slot advances per stored event, holds at saturation, rewinds at each step boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot <= '0;
        end else if (clear || step_close) begin
            slot <= '0;
        end else if (accept && !saturated) begin
            slot <= slot + 1'b1;
        end
    end

    // Step base address moves one full slot block per completed non-final step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q <= '0;
        end else if (clear) begin
            base_q <= '0;
        end else if (step_adv) begin
            base_q <= base_q + size_addr_spike_mem'(size_spike_max);
        end
    end

    // Overflow is sticky across the pass; only a new pass clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (accept && saturated) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/spike_mem_writer.sv
// Collects per-timestep spike indices into spike memory and writes each step's count header.
// Latency: spike memory write 1 cycle after acceptance; count write in the cycle after step_end.
// Backpressure: spike_ready only in COLLECT; events past the slot limit are accepted and dropped.
module spike_mem_writer
    import snn_pkg::*;
#(
    parameter int size_spike          = SIZE_SPIKE_DEF,
    parameter int size_spike_max      = SIZE_SPIKE_MAX_DEF,
    parameter int num_timesteps       = NUM_TIMESTEPS_DEF,
    parameter int size_addr_spike_mem = SIZE_ADDR_SPIKE_MEM_DEF,
    parameter int size_addr_step      = SIZE_ADDR_STEP_DEF,
    parameter int size_count          = SIZE_COUNT_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           spike_valid,
    input  logic [size_spike-1:0]          spike_index,
    output logic                           spike_ready,
    input  logic                           step_end,
    output logic                           mem_we,
    output logic [size_addr_spike_mem-1:0] mem_addr,
    output logic [size_spike-1:0]          mem_data,
    output logic                           cnt_we,
    output logic [size_addr_step-1:0]      cnt_addr,
    output logic [size_count-1:0]          cnt_data,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow
);

    state_t                         state_q;
    state_t                         state_d;
    logic [size_addr_step-1:0]      step_q;
    logic [size_count-1:0]          slot;
    logic [size_addr_spike_mem-1:0] wr_addr;
    logic                           saturated;
    logic                           in_collect;
    logic                           accept;
    logic                           last_step;
    logic                           pass_start;
    logic                           step_close;
    logic                           step_adv;

    assign in_collect = (state_q == COLLECT);
    assign accept     = spike_valid && in_collect;
    assign last_step  = (step_q == size_addr_step'(num_timesteps - 1));
    assign pass_start = (state_q == IDLE) && start;
    assign step_close = (state_q == WRITE_COUNT);
    assign step_adv   = step_close && !last_step;

    spike_slot_counter #(
        .size_spike_max      (size_spike_max),
        .size_addr_spike_mem (size_addr_spike_mem),
        .size_count          (size_count)
    ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .clear      (pass_start),
        .accept     (accept),
        .step_close (step_close),
        .step_adv   (step_adv),
        .slot       (slot),
        .wr_addr    (wr_addr),
        .saturated  (saturated),
        .overflow   (overflow)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only matters in IDLE, step_end only in COLLECT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (start) state_d = COLLECT;
            COLLECT:     if (step_end) state_d = WRITE_COUNT;
            WRITE_COUNT: state_d = last_step ? DONE : COLLECT;
            DONE:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // State-decoded outputs; the count header write carries the slot value that includes any event taken with step_end.
    always_comb begin
        spike_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        cnt_we      = 1'b0;
        cnt_addr    = '0;
        cnt_data    = '0;
        case (state_q)
            COLLECT: begin
                spike_ready = 1'b1;
                busy        = 1'b1;
            end
            WRITE_COUNT: begin
                busy     = 1'b1;
                cnt_we   = 1'b1;
                cnt_addr = step_q;
                cnt_data = slot;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Timestep counter: zero at pass start, advance after each non-final count write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q <= '0;
        end else if (pass_start) begin
            step_q <= '0;
        end else if (step_adv) begin
            step_q <= step_q + 1'b1;
        end
    end

    // Registered spike memory write port: one cycle after each stored acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_we <= accept && !saturated;
            if (accept && !saturated) begin
                mem_addr <= wr_addr;
                mem_data <= spike_index;
            end
        end
    end

endmodule

// File: tb/tb_spike_mem_writer.sv
// Randomized directed bench for spike_mem_writer against a list-based reference model.
// Latency: expects writes 1 cycle after acceptance, count write 1 cycle after step_end, done 1 cycle later.
// Backpressure: drives events only while the model says the writer is collecting.
module tb_spike_mem_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        spike_valid = 1'b0;
    logic [9:0]  spike_index = '0;
    logic        step_end = 1'b0;
    logic        spike_ready;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [9:0]  mem_data;
    logic        cnt_we;
    logic [3:0]  cnt_addr;
    logic [9:0]  cnt_data;
    logic        busy;
    logic        done;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [63:0] got_mem[$];
    logic [63:0] exp_mem[$];
    logic [63:0] got_cnt[$];
    logic [63:0] exp_cnt[$];
    int          got_done[$];
    int          exp_done[$];

    int          pass_counts[10];
    int          sim_step;
    bit          start_during;
    logic [9:0]  fixed_idx[$];

    spike_mem_writer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .spike_valid (spike_valid),
        .spike_index (spike_index),
        .spike_ready (spike_ready),
        .step_end    (step_end),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .cnt_we      (cnt_we),
        .cnt_addr    (cnt_addr),
        .cnt_data    (cnt_data),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe with the cycle it was seen in.
    always @(negedge clk) begin
        if (mem_we) got_mem.push_back({32'(cyc), 16'(mem_addr), 16'(mem_data)});
        if (cnt_we) got_cnt.push_back({32'(cyc), 16'(cnt_addr), 16'(cnt_data)});
        if (done)   got_done.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},    64'(spike_ready), 64'(0));
        chk({tag, "_mem_we"},   64'(mem_we),      64'(0));
        chk({tag, "_mem_addr"}, 64'(mem_addr),    64'(0));
        chk({tag, "_mem_data"}, 64'(mem_data),    64'(0));
        chk({tag, "_cnt_we"},   64'(cnt_we),      64'(0));
        chk({tag, "_cnt_addr"}, 64'(cnt_addr),    64'(0));
        chk({tag, "_cnt_data"}, 64'(cnt_data),    64'(0));
        chk({tag, "_busy"},     64'(busy),        64'(0));
        chk({tag, "_done"},     64'(done),        64'(0));
        chk({tag, "_overflow"}, 64'(overflow),    64'(0));
    endtask

    task automatic compare_all();
        chk("mem_count", 64'(got_mem.size()), 64'(exp_mem.size()));
        for (int i = 0; i < got_mem.size() && i < exp_mem.size(); i++)
            chk("mem_write", got_mem[i], exp_mem[i]);
        chk("cnt_count", 64'(got_cnt.size()), 64'(exp_cnt.size()));
        for (int i = 0; i < got_cnt.size() && i < exp_cnt.size(); i++)
            chk("cnt_write", got_cnt[i], exp_cnt[i]);
        chk("done_count", 64'(got_done.size()), 64'(exp_done.size()));
        for (int i = 0; i < got_done.size() && i < exp_done.size(); i++)
            chk("done_cycle", 64'(got_done[i]), 64'(exp_done[i]));
        got_mem.delete();  exp_mem.delete();
        got_cnt.delete();  exp_cnt.delete();
        got_done.delete(); exp_done.delete();
    endtask

    // One full layer pass: pass_counts[s] events in step s, the last event of
    // sim_step shares its cycle with step_end. Model: event n of step s lands
    // at s*512+n for n<512, later ones are dropped and raise overflow.
    task automatic run_pass();
        int slot;
        int end_c;
        int idx;
        bit ovf;
        bit sim;
        end_c = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovf_cleared", 64'(overflow), 64'(0));
        chk("ready_collect", 64'(spike_ready), 64'(1));
        chk("busy_collect", 64'(busy), 64'(1));
        ovf = 1'b0;
        for (int s = 0; s < 10; s++) begin
            slot = 0;
            sim  = 1'b0;
            for (int e = 0; e < pass_counts[s]; e++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
                if (fixed_idx.size() > 0) idx = int'(fixed_idx.pop_front());
                else                      idx = int'($urandom_range(0, 1023));
                sim = (s == sim_step) && (e == pass_counts[s] - 1);
                spike_valid = 1'b1;
                spike_index = 10'(idx);
                step_end    = sim;
                start       = start_during;
                if (slot < 512) begin
                    exp_mem.push_back({32'(cyc + 1), 16'(s * 512 + slot), 16'(idx)});
                    slot++;
                end else begin
                    ovf = 1'b1;
                end
                end_c = cyc;
                tick();
                spike_valid = 1'b0;
                step_end    = 1'b0;
                start       = 1'b0;
                chk("overflow_track", 64'(overflow), 64'(ovf));
            end
            if (!sim) begin
                step_end = 1'b1;
                end_c    = cyc;
                tick();
                step_end = 1'b0;
            end
            exp_cnt.push_back({32'(end_c + 1), 16'(s), 16'(slot)});
            chk("ready_wcount", 64'(spike_ready), 64'(0));
            chk("busy_wcount", 64'(busy), 64'(1));
            tick();
            if (s < 9) chk("ready_next_step", 64'(spike_ready), 64'(1));
        end
        exp_done.push_back(end_c + 2);
        chk("busy_in_done", 64'(busy), 64'(0));
        tick();
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_ready", 64'(spike_ready), 64'(0));
        chk("idle_done", 64'(done), 64'(0));
        chk("idle_overflow", 64'(overflow), 64'(ovf));
        compare_all();
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 10; i++) pass_counts[i] = 0;
        sim_step     = -1;
        start_during = 1'b0;
        fixed_idx.delete();
    endtask

    initial begin
        // Reset state while reset is held low.
        #3;
        chk_all_zero("reset");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // IDLE ignores spike_valid and step_end.
        spike_valid = 1'b1;
        step_end    = 1'b1;
        spike_index = 10'd77;
        repeat (5) begin
            tick();
            chk("idle_ign_ready", 64'(spike_ready), 64'(0));
            chk("idle_ign_busy", 64'(busy), 64'(0));
        end
        spike_valid = 1'b0;
        step_end    = 1'b0;
        tick();
        compare_all();

        // Basic step: indices 5, 17, 900 in step 0.
        clear_counts();
        pass_counts[0] = 3;
        fixed_idx.push_back(10'd5);
        fixed_idx.push_back(10'd17);
        fixed_idx.push_back(10'd900);
        run_pass();

        // Full pass: step k carries k events.
        clear_counts();
        for (int k = 0; k < 10; k++) pass_counts[k] = k;
        run_pass();

        // Event coincident with step_end in step 2 after one prior event.
        clear_counts();
        pass_counts[2] = 2;
        sim_step = 2;
        fixed_idx.push_back(10'($urandom_range(0, 1023)));
        fixed_idx.push_back(10'd42);
        run_pass();

        // Overflow: 514 events in step 0.
        clear_counts();
        pass_counts[0] = 514;
        run_pass();

        // Random pass with start held high on every event (must be ignored).
        clear_counts();
        for (int k = 0; k < 10; k++) pass_counts[k] = int'($urandom_range(0, 6));
        sim_step = int'($urandom_range(0, 9));
        if (pass_counts[sim_step] == 0) pass_counts[sim_step] = 1;
        start_during = 1'b1;
        run_pass();

        // Reset mid-pass during step 3 collection.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step_end = 1'b1;
            tick();
            step_end = 1'b0;
            tick();
        end
        spike_valid = 1'b1;
        spike_index = 10'd333;
        tick();
        spike_valid = 1'b0;
        chk("pre_reset_mem_we", 64'(mem_we), 64'(1));
        #2 reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        got_mem.delete();  exp_mem.delete();
        got_cnt.delete();  exp_cnt.delete();
        got_done.delete(); exp_done.delete();
        spike_valid = 1'b1;
        step_end    = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (15) begin
            spike_valid = 1'($urandom_range(0, 1));
            step_end    = 1'($urandom_range(0, 1));
            spike_index = 10'($urandom_range(0, 1023));
            tick();
        end
        spike_valid = 1'b0;
        step_end    = 1'b0;
        tick();
        chk("post_reset_ready", 64'(spike_ready), 64'(0));
        chk("post_reset_busy", 64'(busy), 64'(0));
        compare_all();

        // New pass after reset restarts at address 0.
        clear_counts();
        pass_counts[0] = 1;
        pass_counts[3] = 2;
        run_pass();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_mem_writer.md
Name: spike_mem_writer

Overview:
- Write-side counterpart of the spike memory reader used by the spike cache load path.
- Collects a layer's output spike events (neuron indices) per timestep.
- Stores each event at spike memory word timestep*size_spike_max + slot.
- After each timestep, writes that timestep's spike count into a count header memory. This is the same count-header plus index-list layout the spike cache loader consumes.

Parameters:
- size_spike, 10: width of one spike index word.
- size_spike_max, 512: spike slots per timestep.
- num_timesteps, 10: timesteps per layer pass.
- size_addr_spike_mem, 13: spike memory address width; must be ≥ clog2(size_spike_max*num_timesteps).
- size_addr_step, 4: timestep/count address width; must be ≥ clog2(num_timesteps).
- size_count, 10: count width; must be ≥ clog2(size_spike_max+1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a layer pass.
- spike_valid  in  1  spike event present.
- spike_index  in  size_spike  neuron index of the event.
- spike_ready  out  1  writer accepts events this cycle.
- step_end  in  1  one-cycle pulse; current timestep complete.
- mem_we  out  1  spike memory write strobe.
- mem_addr  out  size_addr_spike_mem  spike memory address.
- mem_data  out  size_spike  spike memory write data.
- cnt_we  out  1  count header write strobe.
- cnt_addr  out  size_addr_step  count header address (timestep).
- cnt_data  out  size_count  spike count for that timestep.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse; pass complete.
- overflow  out  1  sticky; at least one event dropped this pass.

Behaviour:
- Reset (asynchronous, while reset=0):
  - State IDLE.
  - All outputs 0: spike_ready, mem_we, mem_addr, mem_data, cnt_we, cnt_addr, cnt_data, busy, done, overflow.
  - Internal step and slot counters 0.
  - Reset asserted mid-pass abandons the pass; no further writes are issued.
- States: IDLE, COLLECT, WRITE_COUNT, DONE.
- IDLE:
  - start=1 → COLLECT next cycle; step=0, slot=0, overflow cleared.
  - start is ignored in every other state.
- COLLECT:
  - spike_ready=1, busy=1.
  - An event is accepted when spike_valid && spike_ready.
  - If slot < size_spike_max at acceptance:
    - next cycle: mem_we=1, mem_addr=step*size_spike_max+slot, mem_data=spike_index;
    - slot increments.
  - If slot == size_spike_max at acceptance: the event is still accepted (no backpressure) but no write is issued; overflow←1; slot holds.
  - Write latency is exactly 1 cycle from acceptance. mem_we is 0 in every cycle without a preceding accepted, non-dropped event.
  - step_end=1 → WRITE_COUNT next cycle.
  - step_end and spike_valid in the same cycle: the event belongs to the current step and is included in the count.
- WRITE_COUNT (1 cycle):
  - spike_ready=0.
  - cnt_we=1, cnt_addr=step, cnt_data=slot (final value, including any event accepted with step_end).
  - slot←0.
  - If step==num_timesteps-1 → DONE; otherwise step+1 → COLLECT.
- DONE (1 cycle):
  - done=1, busy=0 on exit → IDLE.
  - overflow holds until the next start or reset.
- step_end outside COLLECT is ignored. spike_valid while spike_ready=0 is ignored; the source must hold it.
- Timesteps with zero events still produce a count write of 0.
- mem_addr arithmetic is unsigned. The multiply reduces to a running base register incremented by size_spike_max per step; no multiplier.

Decomposition:
- Shared package snn_pkg:
  - parameter defaults above;
  - state enum {IDLE, COLLECT, WRITE_COUNT, DONE};
  - localparam SPIKE_MEM_DEPTH = size_spike_max*num_timesteps.
- One sub-module: spike_slot_counter. Holds the slot counter, saturation at size_spike_max, overflow detect and step base address. It outputs the write address and the saturated flag.

Test Plan:
- Basic step: start; 3 events idx 5,17,900 in step 0; step_end → mem writes at addr 0,1,2 with data 5,17,900, each 1 cycle after acceptance; cnt_we with cnt_addr=0, cnt_data=3.
- Full pass: 10 steps, step k carries k events → mem_addr base k*512; 10 count writes with data 0..9; done pulses once, one cycle after the step 9 count write; busy=0 afterwards.
- Simultaneous: spike_valid idx 42 coinciding with step_end in step 2 after 1 prior event → write at addr 1025 data 42; cnt_data=2 at cnt_addr=2.
- Overflow: 514 events in step 0 → 512 writes at addr 0..511; overflow=1 from the 513th acceptance; cnt_data=512; overflow stays 1 through done and clears on the next start.
- Reset mid-pass: reset low during step 3 collection → all outputs 0 immediately (async); no mem_we/cnt_we after release until a new start; new pass restarts at addr 0.
- Ignored inputs: start during COLLECT and step_end/spike_valid in IDLE → no state change, no writes, spike_ready=0 in IDLE.
